// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo line-buffer blocks.
//
// Contents:
//   DEFAULT_DATA_WIDTH : default pixel-group word width (AXI data plus sync bits)
//   DEFAULT_MAX_DELAY  : default maximum line length (one full-HD line)
//   clamp_len()        : maps a programmed line length onto the legal range 1..max_len
package stereo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 96;
    localparam int DEFAULT_MAX_DELAY  = 1920;

    // A length of 0 and any length beyond the RAM depth both select the full depth.
    function automatic int clamp_len(input int len, input int max_len);
        if (len == 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/sp_ram_rf.sv
// Single-port read-first RAM with a registered read port (latency 1).
//
// The row is split into NUM_SLOTS slots of SLOT_W bits, each with its own write
// enable, so one slot can be overwritten while the whole old row is read back.
// Contents are never reset.
//
// Ports:
//   clk   : clock
//   en    : port enable; with en=0 nothing is read or written and rdata holds
//   we    : per-slot write enable (only honoured while en=1)
//   addr  : row address
//   wdata : data written into every slot whose we bit is set
//   rdata : old contents of the row addressed on the last enabled cycle
module sp_ram_rf #(
    parameter int DEPTH     = 1920,
    parameter int ADDR_W    = 11,
    parameter int SLOT_W    = 96,
    parameter int NUM_SLOTS = 4
) (
    input  logic                          clk,
    input  logic                          en,
    input  logic [NUM_SLOTS-1:0]          we,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [SLOT_W-1:0]             wdata,
    output logic [NUM_SLOTS*SLOT_W-1:0]   rdata
);

    logic [NUM_SLOTS*SLOT_W-1:0] mem [DEPTH];
    logic [NUM_SLOTS*SLOT_W-1:0] rdata_q;

    // Read-first: the read sees the row as it was before this cycle's write.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (we[s]) begin
                    mem[addr][s*SLOT_W +: SLOT_W] <= wdata;
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer_multitap_xppc.sv
// Multi-tap line buffer: NUM_TAPS cascaded line delays held in one block RAM,
// producing the vertical window (rows y-1 .. y-NUM_TAPS) for the census/SAD
// context generators.
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset; wins over ce and eol
//   ce        : advance enable. There is no back-pressure: every cycle with ce=1
//               accepts exactly one din word and advances the window by one
//               column; with ce=0 every output holds.
//   din       : current-row word
//   eol       : last word of a line (only looked at when ce=1)
//   line_len  : programmed line length; taken at reset and at every wrap
//   taps      : tap k at [k*DATA_WIDTH +: DATA_WIDTH] is din delayed k+1 lines
//   tap_valid : bit k set once tap k carries real data (invalid taps read 0)
//   pos       : current write/read column address
//
// Storage layout: each RAM row holds the last NUM_TAPS lines of one column,
// one line per slot. Successive lines rotate through the slots, so a column
// visit only writes din into the slot holding the oldest line; the read-first
// port returns that oldest line together with the newer ones in the same
// access. The output stage rotates the slots back into tap order. This gives
// tap k exactly (k+1) lines of delay with a single read per ce.
module line_buffer_multitap_xppc
    import stereo_pkg::*;
#(
    parameter int  DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int  MAX_DELAY     = DEFAULT_MAX_DELAY,
    parameter int  NUM_TAPS      = 4,
    parameter bit  RESYNC_ON_EOL = 1'b1,
    localparam int ADDR_W        = $clog2(MAX_DELAY)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           eol,
    input  logic [ADDR_W:0]                line_len,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps,
    output logic [NUM_TAPS-1:0]            tap_valid,
    output logic [ADDR_W-1:0]              pos
);

    localparam int LEN_W  = ADDR_W + 1;
    localparam int FILL_W = $clog2(NUM_TAPS + 1);
    localparam int SLOT_N = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int ROW_W  = NUM_TAPS * DATA_WIDTH;

    logic [ADDR_W-1:0]   pos_q, pos_d;
    logic [LEN_W-1:0]    active_len_q, active_len_d;
    logic [FILL_W-1:0]   lines_filled_q, lines_filled_d;
    logic [NUM_TAPS-1:0] tap_valid_q, tap_valid_d;
    logic [SLOT_N-1:0]   wr_slot_q, wr_slot_d;   // slot receiving the current line
    logic [SLOT_N-1:0]   rd_slot_q, rd_slot_d;   // wr_slot at the time of the last read

    logic [LEN_W-1:0]    len_clamped;
    logic                wrap;
    logic                ram_en;
    logic [NUM_TAPS-1:0] slot_we;
    logic [ROW_W-1:0]    row_rdata;

    always_comb begin
        len_clamped = LEN_W'(clamp_len(int'(line_len), MAX_DELAY));
        // Compared at LEN_W bits so active_len = 2^ADDR_W does not truncate.
        wrap = ce && ((RESYNC_ON_EOL && eol) ||
                      ({1'b0, pos_q} == (active_len_q - LEN_W'(1))));

        pos_d          = pos_q;
        active_len_d   = active_len_q;
        lines_filled_d = lines_filled_q;
        tap_valid_d    = tap_valid_q;
        wr_slot_d      = wr_slot_q;
        rd_slot_d      = rd_slot_q;

        if (rst) begin
            pos_d          = '0;
            active_len_d   = len_clamped;
            lines_filled_d = '0;
            tap_valid_d    = '0;
            wr_slot_d      = '0;
            rd_slot_d      = '0;
        end else if (ce) begin
            pos_d     = wrap ? '0 : pos_q + ADDR_W'(1);
            rd_slot_d = wr_slot_q;
            // Valid flags are taken alongside the RAM read, from the fill
            // count before this word's wrap.
            for (int k = 0; k < NUM_TAPS; k++) begin
                tap_valid_d[k] = (lines_filled_q > FILL_W'(k));
            end
            if (wrap) begin
                active_len_d = len_clamped;
                if (lines_filled_q != FILL_W'(NUM_TAPS)) begin
                    lines_filled_d = lines_filled_q + FILL_W'(1);
                end
                wr_slot_d = (wr_slot_q == SLOT_N'(NUM_TAPS - 1)) ? '0 : wr_slot_q + SLOT_N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        pos_q          <= pos_d;
        active_len_q   <= active_len_d;
        lines_filled_q <= lines_filled_d;
        tap_valid_q    <= tap_valid_d;
        wr_slot_q      <= wr_slot_d;
        rd_slot_q      <= rd_slot_d;
    end

    assign ram_en = ce && !rst;

    always_comb begin
        for (int s = 0; s < NUM_TAPS; s++) begin
            slot_we[s] = (wr_slot_q == SLOT_N'(s));
        end
    end

    sp_ram_rf #(
        .DEPTH     (MAX_DELAY),
        .ADDR_W    (ADDR_W),
        .SLOT_W    (DATA_WIDTH),
        .NUM_SLOTS (NUM_TAPS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (slot_we),
        .addr  (pos_q),
        .wdata (din),
        .rdata (row_rdata)
    );

    // Tap k lives in the slot written k+1 lines before the line that did the
    // read; tap NUM_TAPS-1 is the slot that was just overwritten (read-first).
    always_comb begin
        int slot;
        slot = 0;
        taps = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            slot = int'(rd_slot_q) + NUM_TAPS - 1 - k;
            if (slot >= NUM_TAPS) begin
                slot = slot - NUM_TAPS;
            end
            if (tap_valid_q[k]) begin
                taps[k*DATA_WIDTH +: DATA_WIDTH] = row_rdata[slot*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign tap_valid = tap_valid_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_line_buffer_multitap_xppc.sv
// Directed bench for line_buffer_multitap_xppc (DATA_WIDTH=16, MAX_DELAY=16,
// NUM_TAPS=4, RESYNC_ON_EOL=1). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_line_buffer_multitap_xppc;

    localparam int W    = 16;
    localparam int MAXD = 16;
    localparam int NT   = 4;
    localparam int AW   = $clog2(MAXD);

    logic            clk;
    logic            rst;
    logic            ce;
    logic [W-1:0]    din;
    logic            eol;
    logic [AW:0]     line_len;
    logic [NT*W-1:0] taps;
    logic [NT-1:0]   tap_valid;
    logic [AW-1:0]   pos;

    int tests_run    = 0;
    int tests_failed = 0;

    line_buffer_multitap_xppc #(
        .DATA_WIDTH    (W),
        .MAX_DELAY     (MAXD),
        .NUM_TAPS      (NT),
        .RESYNC_ON_EOL (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .din       (din),
        .eol       (eol),
        .line_len  (line_len),
        .taps      (taps),
        .tap_valid (tap_valid),
        .pos       (pos)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected values for a constant-length stream din=0,1,2,...
    function automatic logic [NT*W-1:0] exp_taps(input int w, input int len);
        logic [NT*W-1:0] r;
        int f;
        r = '0;
        f = w / len;
        if (f > NT) f = NT;
        for (int k = 0; k < f; k++) r[k*W +: W] = W'(w - len * (k + 1));
        return r;
    endfunction

    function automatic logic [NT-1:0] exp_valid(input int w, input int len);
        int f;
        f = w / len;
        if (f > NT) f = NT;
        return NT'((1 << f) - 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic ce_i, input logic [W-1:0] din_i, input logic eol_i);
        ce  = ce_i;
        din = din_i;
        eol = eol_i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [AW:0] len);
        rst      = 1'b1;
        ce       = 1'b0;
        eol      = 1'b0;
        line_len = len;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // rst together with ce and eol: reset must win.
        rst      = 1'b1;
        ce       = 1'b1;
        eol      = 1'b1;
        din      = 16'h1234;
        line_len = 5'd8;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ce  = 1'b0;
        eol = 1'b0;
        tests_run++;
        if (taps !== '0) begin
            tests_failed++;
            $display("FAIL reset_taps got=%h exp=0", taps);
        end
        tests_run++;
        if (tap_valid !== '0) begin
            tests_failed++;
            $display("FAIL reset_valid got=%b exp=0000", tap_valid);
        end
        tests_run++;
        if (pos !== '0) begin
            tests_failed++;
            $display("FAIL reset_pos got=%0d exp=0", pos);
        end
    endtask

    task automatic test_basic(input string tag);
        for (int w = 0; w < 40; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (pos !== AW'((w + 1) % 8)) begin
                tests_failed++;
                $display("FAIL %s_pos w=%0d got=%0d exp=%0d", tag, w, pos, (w + 1) % 8);
            end
            tests_run++;
            if (tap_valid !== exp_valid(w, 8)) begin
                tests_failed++;
                $display("FAIL %s_valid w=%0d got=%b exp=%b", tag, w, tap_valid, exp_valid(w, 8));
            end
            tests_run++;
            if (taps !== exp_taps(w, 8)) begin
                tests_failed++;
                $display("FAIL %s_taps w=%0d got=%h exp=%h", tag, w, taps, exp_taps(w, 8));
            end
        end
    endtask

    task automatic test_ce_gaps();
        int w;
        w = 0;
        do_reset(5'd8);
        for (int c = 0; c < 80; c++) begin
            if (c % 2 == 0) begin
                drive(1'b1, W'(w), 1'b0);
                w++;
            end else begin
                // eol on an idle cycle must be ignored.
                drive(1'b0, 16'hdead, 1'b1);
            end
            tests_run++;
            if (pos !== AW'(w % 8) || tap_valid !== exp_valid(w - 1, 8) ||
                taps !== exp_taps(w - 1, 8)) begin
                tests_failed++;
                $display("FAIL ce_gaps c=%0d got pos=%0d v=%b t=%h exp pos=%0d v=%b t=%h",
                         c, pos, tap_valid, taps, w % 8, exp_valid(w - 1, 8), exp_taps(w - 1, 8));
            end
        end
    endtask

    task automatic test_len_change();
        do_reset(5'd8);
        for (int w = 0; w < 3; w++) drive(1'b1, W'(w), 1'b0);
        line_len = 5'd5;   // pos is 3 here: current line must still run to 7
        for (int w = 3; w < 8; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (pos !== AW'((w + 1) % 8)) begin
                tests_failed++;
                $display("FAIL len_chg_pos8 w=%0d got=%0d exp=%0d", w, pos, (w + 1) % 8);
            end
        end
        for (int w = 8; w < 13; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (pos !== AW'((w - 7) % 5) || tap_valid !== 4'b0001 || taps[W-1:0] !== W'(w - 8)) begin
                tests_failed++;
                $display("FAIL len_chg_line1 w=%0d got pos=%0d v=%b t0=%0d exp pos=%0d v=0001 t0=%0d",
                         w, pos, tap_valid, taps[W-1:0], (w - 7) % 5, w - 8);
            end
        end
        for (int w = 13; w < 18; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (pos !== AW'((w - 12) % 5) || tap_valid !== 4'b0011 ||
                taps[W-1:0] !== W'(w - 5) || taps[2*W-1:W] !== W'(w - 13)) begin
                tests_failed++;
                $display("FAIL len_chg_line2 w=%0d got pos=%0d v=%b t0=%0d t1=%0d exp pos=%0d v=0011 t0=%0d t1=%0d",
                         w, pos, tap_valid, taps[W-1:0], taps[2*W-1:W], (w - 12) % 5, w - 5, w - 13);
            end
        end
    endtask

    task automatic test_eol();
        do_reset(5'd8);
        for (int w = 0; w < 6; w++) drive(1'b1, W'(w), (w == 5));
        tests_run++;
        if (pos !== '0) begin
            tests_failed++;
            $display("FAIL eol_early_pos got=%0d exp=0", pos);
        end
        drive(1'b1, W'(6), 1'b0);
        tests_run++;
        if (tap_valid !== 4'b0001 || taps[W-1:0] !== W'(0) || pos !== AW'(1)) begin
            tests_failed++;
            $display("FAIL eol_early_fill got v=%b t0=%0d pos=%0d exp v=0001 t0=0 pos=1",
                     tap_valid, taps[W-1:0], pos);
        end
        for (int w = 7; w < 12; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (taps[W-1:0] !== W'(w - 6) || pos !== AW'(w - 5)) begin
                tests_failed++;
                $display("FAIL eol_line1 w=%0d got t0=%0d pos=%0d exp t0=%0d pos=%0d",
                         w, taps[W-1:0], pos, w - 6, w - 5);
            end
        end
        drive(1'b1, W'(12), 1'b0);
        tests_run++;
        if (pos !== AW'(7)) begin
            tests_failed++;
            $display("FAIL eol_pos7 got=%0d exp=7", pos);
        end
        // eol on the natural last column: one wrap only.
        drive(1'b1, W'(13), 1'b1);
        tests_run++;
        if (pos !== '0) begin
            tests_failed++;
            $display("FAIL eol_natural_pos got=%0d exp=0", pos);
        end
        drive(1'b1, W'(14), 1'b0);
        tests_run++;
        if (tap_valid !== 4'b0011 || taps[W-1:0] !== W'(6) || taps[2*W-1:W] !== W'(0)) begin
            tests_failed++;
            $display("FAIL eol_single_wrap got v=%b t0=%0d t1=%0d exp v=0011 t0=6 t1=0",
                     tap_valid, taps[W-1:0], taps[2*W-1:W]);
        end
    endtask

    task automatic test_clamp();
        do_reset(5'd0);   // 0 selects MAX_DELAY
        for (int w = 0; w < 16; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (pos !== AW'((w + 1) % 16)) begin
                tests_failed++;
                $display("FAIL clamp0_pos w=%0d got=%0d exp=%0d", w, pos, (w + 1) % 16);
            end
        end
        line_len = 5'(MAXD + 3);
        for (int w = 16; w < 32; w++) begin
            drive(1'b1, W'(w), 1'b0);
            tests_run++;
            if (pos !== AW'((w + 1) % 16) || tap_valid !== 4'b0001 || taps[W-1:0] !== W'(w - 16)) begin
                tests_failed++;
                $display("FAIL clamp_line1 w=%0d got pos=%0d v=%b t0=%0d exp pos=%0d v=0001 t0=%0d",
                         w, pos, tap_valid, taps[W-1:0], (w + 1) % 16, w - 16);
            end
        end
        drive(1'b1, W'(32), 1'b0);
        tests_run++;
        if (pos !== AW'(1) || tap_valid !== 4'b0011 || taps[W-1:0] !== W'(16) || taps[2*W-1:W] !== W'(0)) begin
            tests_failed++;
            $display("FAIL clamp_big got pos=%0d v=%b t0=%0d t1=%0d exp pos=1 v=0011 t0=16 t1=0",
                     pos, tap_valid, taps[W-1:0], taps[2*W-1:W]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(5'd8);
        for (int w = 0; w < 20; w++) drive(1'b1, W'(w + 100), 1'b0);
        rst = 1'b1;
        drive(1'b1, 16'hbeef, 1'b0);
        rst = 1'b0;
        tests_run++;
        if (taps !== '0 || tap_valid !== '0 || pos !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid got t=%h v=%b pos=%0d exp t=0 v=0000 pos=0", taps, tap_valid, pos);
        end
        test_basic("refill");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst      = 1'b1;
        ce       = 1'b0;
        din      = '0;
        eol      = 1'b0;
        line_len = 5'd8;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        do_reset(5'd8);
        test_basic("basic");
        test_ce_gaps();
        test_len_change();
        test_eol();
        test_clamp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
